calc_host: RTL and testbench
============================

CALC_HOST -- requirements
Module: calc_host

Interface
REQ-001 Parameter: XW, 8, operand width.
REQ-002 Parameter: RW, 16, result width.
REQ-003 Parameter: TW, 8, timeout counter width (used only with HOST_TIMEOUT_EN).
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  1  upstream operand available.
REQ-007 Port: req_x  input  XW  upstream operand.
REQ-008 Port: req_ready  output  1  host accepts operand this cycle.
REQ-009 Port: core_start  output  1  start pulse to the compute core.
REQ-010 Port: core_x  output  XW  registered operand presented to the core.
REQ-011 Port: core_ready  input  1  core idle/done indication.
REQ-012 Port: core_result  input  RW  core result, valid when core_ready returns high.
REQ-013 Port: res_valid  output  1  result held for downstream.
REQ-014 Port: res_data  output  RW  captured result.
REQ-015 Port: res_ack  input  1  downstream consumes result.
REQ-016 Port: timeout_err  output  1  sticky core-timeout flag.

Function
REQ-017 States: IDLE, START, ACCEPT, RUN, HOLD; registered state and outputs, no combinational input-to-output paths.
REQ-018 IDLE: req_ready=1 only when core_ready=1; on req_valid&&req_ready, latch req_x into core_x, go START.
REQ-019 START: core_start=1 for exactly one cycle; next state ACCEPT.
REQ-020 ACCEPT: wait for core_ready=0 (core left idle); then RUN; core_start stays 0.
REQ-021 RUN: wait for core_ready=1; that cycle capture core_result into res_data, set res_valid, go HOLD.
REQ-022 HOLD: res_valid and res_data stable until res_ack=1; on res_ack clear res_valid, go IDLE.
REQ-023 res_ack in HOLD together with req_valid: res_ack taken, req not accepted until next cycle in IDLE (one-cycle bubble).
REQ-024 res_ack outside HOLD ignored; req_valid outside IDLE ignored (req_ready=0).
REQ-025 Minimum request-to-res_valid latency: 3 cycles plus core run time; core_x unchanged from START until return to IDLE.
REQ-026 timeout_err clears only on rst.

Reset
REQ-027 rst=1 forces asynchronously: state IDLE, core_start=0, core_x=0, res_valid=0, res_data=0, timeout_err=0, timeout counter=0.
REQ-028 rst asserted mid-transaction aborts it; no result delivered; req_ready follows core_ready from first clock after release.

Configuration
REQ-029 Macro HOST_TIMEOUT_EN defined: TW-bit counter clears on entering ACCEPT, increments each cycle in ACCEPT/RUN; on reaching all-ones, set timeout_err, res_valid stays 0, go IDLE.
REQ-030 Macro HOST_TIMEOUT_EN undefined: no counter; ACCEPT/RUN wait indefinitely; timeout_err tied 0.

Verification
REQ-031 Reset, core_ready=1, req_valid=1 x=8'h05 -> core_start high one cycle 2 cycles after accept, core_x=8'h05.
REQ-032 Core model drops ready 1 cycle after start, raises after 12 cycles with result 16'h1234 -> res_valid=1, res_data=16'h1234 held until res_ack.
REQ-033 res_ack held 0 for 20 cycles with req_valid=1 -> req_ready=0 throughout, no second core_start.
REQ-034 rst pulsed while in RUN -> all outputs reset, res_valid never asserts for aborted operand.
REQ-035 HOST_TIMEOUT_EN, TW=8, core never returns ready -> timeout_err=1 after 255 cycles in ACCEPT/RUN, state IDLE, res_valid=0.
REQ-036 Back-to-back: res_ack and req_valid both 1 in HOLD -> next accept exactly one cycle later, second result correct.

Source files
------------

// File: rtl/calc_host.sv
// Host-side sequencer: accepts an operand, starts the compute core, waits for its result and holds it for downstream.
// Optional core-timeout watchdog enabled by defining HOST_TIMEOUT_EN.
module calc_host #(
    parameter int XW = 8,
    parameter int RW = 16,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [XW-1:0] req_x,
    output logic          req_ready,
    output logic          core_start,
    output logic [XW-1:0] core_x,
    input  logic          core_ready,
    input  logic [RW-1:0] core_result,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    input  logic          res_ack,
    output logic          timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACCEPT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t state, state_nx;
    logic   timeout_hit;

`ifdef HOST_TIMEOUT_EN
    // Fires on the cycle whose increment brings the counter to all-ones.
    localparam logic [TW-1:0] TLAST = {{(TW-1){1'b1}}, 1'b0};
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == S_START) begin
            tcnt <= '0;
        end else if (state == S_ACCEPT || state == S_RUN) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_ACCEPT || state == S_RUN) && (tcnt == TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if ((state == S_ACCEPT || state == S_RUN) && state_nx == S_IDLE) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = |{TW{1'b0}};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (req_valid && req_ready) state_nx = S_START;
            S_START:  state_nx = S_ACCEPT;
            S_ACCEPT: begin
                if (!core_ready)      state_nx = S_RUN;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_RUN: begin
                if (core_ready)       state_nx = S_HOLD;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_HOLD:   if (res_ack) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // All outputs are decoded from the next state so nothing is combinational from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            core_start <= 1'b0;
            core_x     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            state      <= state_nx;
            core_start <= (state_nx == S_START);
            req_ready  <= (state_nx == S_IDLE) && core_ready;
            if (state == S_IDLE && req_valid && req_ready) begin
                core_x <= req_x;
            end
            if (state == S_RUN && core_ready) begin
                res_valid <= 1'b1;
                res_data  <= core_result;
            end else if (state == S_HOLD && res_ack) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_host.sv
// Self-checking bench for calc_host: behavioural core model plus transaction-level expectations.
module tb_calc_host;

    localparam int XW = 8;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [XW-1:0] req_x;
    logic          req_ready;
    logic          core_start;
    logic [XW-1:0] core_x;
    logic          core_ready;
    logic [RW-1:0] core_result;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_ack;
    logic          timeout_err;

    int compared   = 0;
    int mismatched = 0;

    int            core_d    = 1;
    int            core_run  = 4;
    logic [RW-1:0] core_val  = '0;
    bit            core_hang = 1'b0;

    calc_host #(.XW(XW), .RW(RW), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .core_start(core_start), .core_x(core_x),
        .core_ready(core_ready), .core_result(core_result),
        .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Core: leaves idle core_d cycles after seeing start, busy core_run cycles (or until released when hanging).
    initial begin
        core_ready  = 1'b1;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                repeat (core_d) @(negedge clk);
                core_ready  = 1'b0;
                core_result = RW'($urandom);
                if (core_hang) begin
                    while (core_hang) @(negedge clk);
                end else begin
                    repeat (core_run) @(negedge clk);
                end
                core_ready  = 1'b1;
                core_result = core_val;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_x"}, core_x, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // Present x, wait for readiness, and confirm the one-cycle start pulse that follows the accept.
    task automatic accept_req(input logic [XW-1:0] x, output int waited);
        req_valid = 1'b1;
        req_x     = x;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_wait", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_x     = XW'($urandom);
        check("core_start_pulse", core_start, 1);
        check("core_x_latched", core_x, x);
        @(negedge clk);
        check("core_start_single", core_start, 0);
    endtask

    // Expected: result visible exp_edges clock edges after the accepting edge.
    task automatic wait_result(input logic [XW-1:0] x, input int exp_edges, input logic [RW-1:0] exp_val);
        int edges = 1;
        while (res_valid !== 1'b1 && edges < 400) begin
            check("core_x_stable", core_x, x);
            check("no_restart", core_start, 0);
            check("req_ready_busy", req_ready, 0);
            res_ack   = 1'($urandom);
            req_valid = 1'($urandom);
            req_x     = XW'($urandom);
            @(negedge clk);
            edges++;
        end
        res_ack   = 1'b0;
        req_valid = 1'b0;
        check("latency", edges, exp_edges);
        check("res_data", res_data, exp_val);
    endtask

    task automatic hold_and_ack(input int hold, input logic [RW-1:0] exp_val,
                                input bit b2b, input logic [XW-1:0] nx);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_x     = XW'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp_val);
            check("hold_no_ready", req_ready, 0);
            check("hold_no_start", core_start, 0);
        end
        res_ack   = 1'b1;
        req_valid = b2b;
        req_x     = nx;
        @(negedge clk);
        res_ack = 1'b0;
        check("ack_clears", res_valid, 0);
        check("bubble_no_start", core_start, 0);
        check("ready_after_ack", req_ready, 1);
    endtask

    initial begin
        int            w;
        int            edges;
        bit            pend;
        bit            b;
        logic [XW-1:0] x;
        logic [XW-1:0] nx;
        logic [RW-1:0] val;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_x     = '0;
        res_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Directed: operand 0x05, 12-cycle core, result held 20 cycles with requests pending.
        core_d = 1; core_run = 12; core_val = 16'h1234;
        accept_req(8'h05, w);
        wait_result(8'h05, 1 + 1 + 12, 16'h1234);
        hold_and_ack(20, 16'h1234, 1'b0, 8'h00);

        // Directed back-to-back: ack and new request together.
        core_d = 2; core_run = 3; core_val = 16'hBEEF;
        accept_req(8'hA5, w);
        wait_result(8'hA5, 1 + 2 + 3, 16'hBEEF);
        core_d = 1; core_run = 5; core_val = 16'h0F0F;
        hold_and_ack(2, 16'hBEEF, 1'b1, 8'h3C);
        accept_req(8'h3C, w);
        check("b2b_no_wait", w, 0);
        wait_result(8'h3C, 1 + 1 + 5, 16'h0F0F);
        hold_and_ack(1, 16'h0F0F, 1'b0, 8'h00);

        // Randomized transactions.
        pend = 1'b0;
        x    = XW'($urandom);
        for (int i = 0; i < 12; i++) begin
            core_d   = $urandom_range(1, 3);
            core_run = $urandom_range(1, 10);
            val      = RW'($urandom);
            core_val = val;
            accept_req(x, w);
            if (pend) check("b2b_no_wait_rand", w, 0);
            wait_result(x, 1 + core_d + core_run, val);
            nx = XW'($urandom);
            b  = (i == 11) ? 1'b0 : 1'($urandom);
            hold_and_ack($urandom_range(0, 4), val, b, nx);
            pend = b;
            x    = nx;
        end

        // Abort in the middle of a core run.
        core_d = 1; core_run = 12; core_val = 16'hDEAD;
        accept_req(8'h77, w);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_follows_busy_core", req_ready, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_result", res_valid, 0);
            check("abort_no_start", core_start, 0);
        end
        check("abort_ready_again", req_ready, 1);

`ifdef HOST_TIMEOUT_EN
        // Core that never finishes: watchdog expires after 255 ACCEPT/RUN cycles.
        core_hang = 1'b1; core_d = 1; core_val = 16'h5555;
        accept_req(8'h99, w);
        edges = 1;
        while (timeout_err !== 1'b1 && edges < 400) begin
            check("to_no_result", res_valid, 0);
            @(negedge clk);
            edges++;
        end
        check("timeout_latency", edges, 256);
        check("timeout_no_result", res_valid, 0);
        check("timeout_ready_core_busy", req_ready, 0);
        core_hang = 1'b0;
        w = 0;
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("timeout_back_idle", req_ready, 1);
        check("timeout_no_result_late", res_valid, 0);
        core_d = 1; core_run = 2; core_val = 16'h4321;
        accept_req(8'h42, w);
        wait_result(8'h42, 4, 16'h4321);
        hold_and_ack(0, 16'h4321, 1'b0, 8'h00);
        check("timeout_sticky", timeout_err, 1);
        rst = 1'b1;
        #1;
        check("timeout_cleared", timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        // Without the watchdog a slow core is simply waited for.
        core_hang = 1'b1; core_d = 1; core_val = 16'h5A5A;
        accept_req(8'h99, w);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("wait_no_result", res_valid, 0);
            check("wait_no_timeout", timeout_err, 0);
        end
        core_hang = 1'b0;
        w = 0;
        while (res_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("slow_core_valid", res_valid, 1);
        check("slow_core_data", res_data, 16'h5A5A);
        check("slow_core_x", core_x, 8'h99);
        hold_and_ack(1, 16'h5A5A, 1'b0, 8'h00);
        check("no_timeout_flag", timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
